shifter_arbiter: RTL and testbench

SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

---
 rtl/shifter_arbiter.sv | 163 ++++++++++++++++
 tb/tb_shifter_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Five-port round-robin arbiter feeding a shared shifter. A sending handshake holds the
// shifter until its tail flit or a stall timeout; a receiving handshake is single-flit.
module shifter_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   req,
  input  logic [159:0] flit_in,
  output logic [4:0]   ack,
  output logic [4:0]   grant,
  output logic         sh_enable,
  output logic [31:0]  flit_out,
  output logic         busy,
  output logic         timeout_err
);

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned STALL_W   = 8;

  localparam logic [1:0] TYPE_HS   = 2'b11;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam int unsigned HS_DIR_BIT = 21;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 sh_enable_q, sh_enable_d;
  logic [FLIT_W-1:0]    flit_out_q, flit_out_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [FLIT_W-1:0]    flits [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;
  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W:0]       idx;

  // Unpack the per-port flits and flag ports presenting a handshake
  always_comb begin
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      flits[p] = flit_in[p*FLIT_W +: FLIT_W];
      elig[p]  = req[p] && (flit_in[p*FLIT_W + 30 +: 2] == TYPE_HS);
    end
  end

  // Round-robin search starting just after the last winner
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= int'(NUM_PORTS); i++) begin
      idx = 4'(ptr_q) + 4'(i);
      if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
      if (!found && elig[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      ptr_q         <= 3'd4;
      stall_q       <= '0;
      grant_q       <= '0;
      sh_enable_q   <= 1'b0;
      flit_out_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      stall_q       <= stall_d;
      grant_q       <= grant_d;
      sh_enable_q   <= sh_enable_d;
      flit_out_q    <= flit_out_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    stall_d       = stall_q;
    grant_d       = grant_q;
    sh_enable_d   = sh_enable_q;
    flit_out_d    = flit_out_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;
    ack           = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          ack[winner] = 1'b1;
          grant_d     = 5'(5'b00001 << winner);
          flit_out_d  = flits[winner];
          sh_enable_d = 1'b1;
          ptr_d       = winner;
          owner_d     = winner;
          stall_d     = '0;
          // Receiving handshakes are a single flit and never hold the shifter
          if (!flits[winner][HS_DIR_BIT]) begin
            state_d = HOLD;
            busy_d  = 1'b1;
          end else begin
            busy_d  = 1'b0;
          end
        end else begin
          grant_d     = '0;
          sh_enable_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      HOLD: begin
        if (req[owner_q]) begin
          ack[owner_q] = 1'b1;
          stall_d      = '0;
          flit_out_d   = flits[owner_q];
          sh_enable_d  = 1'b1;
          // Grant stays up for the tail's cycle on the shifter
          if (flits[owner_q][31:30] == TYPE_TAIL) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          sh_enable_d = 1'b0;
          if (stall_q == 8'(TIMEOUT - 1)) begin
            state_d       = IDLE;
            stall_d       = '0;
            grant_d       = '0;
            busy_d        = 1'b0;
            timeout_err_d = 1'b1;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) ack = '0;
  end

  assign grant       = grant_q;
  assign sh_enable   = sh_enable_q;
  assign flit_out    = flit_out_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed vector bench for shifter_arbiter: table of per-cycle inputs and expected outputs
// plus hand-written timeout and mid-packet reset sequences.
module tb_shifter_arbiter;

  localparam logic [31:0] HS_S = 32'hC000_0000;
  localparam logic [31:0] HS_R = 32'hC020_0000;
  localparam logic [31:0] BODY = 32'h4000_0001;
  localparam logic [31:0] TAIL = 32'h8000_0002;
  localparam logic [31:0] NONE = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   req;
  logic [159:0] flit_in;
  logic [4:0]   ack;
  logic [4:0]   grant;
  logic         sh_enable;
  logic [31:0]  flit_out;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic [4:0]   req;
    logic [159:0] flits;
    logic [4:0]   ack;
    logic [4:0]   grant;
    logic         sh;
    logic [31:0]  fout;
    logic         busy;
    logic         terr;
  } vec_t;

  shifter_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_in(flit_in), .ack(ack), .grant(grant),
    .sh_enable(sh_enable), .flit_out(flit_out), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] pk(input logic [31:0] f0, input logic [31:0] f1,
                                      input logic [31:0] f2, input logic [31:0] f3,
                                      input logic [31:0] f4);
    return {f4, f3, f2, f1, f0};
  endfunction

  function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [159:0] f,
                              input logic [4:0] a, input logic [4:0] g, input logic s,
                              input logic [31:0] fo, input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.flits = f; v.ack = a; v.grant = g;
    v.sh = s; v.fout = fo; v.busy = b; v.terr = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after negedge, check ack before the edge, registers after it
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst = v.rst; req = v.req; flit_in = v.flits;
    #1;
    chk({tag, " ack"}, 32'(ack), 32'(v.ack));
    @(posedge clk);
    #1;
    chk({tag, " grant"}, 32'(grant), 32'(v.grant));
    chk({tag, " sh_enable"}, 32'(sh_enable), 32'(v.sh));
    chk({tag, " flit_out"}, flit_out, v.fout);
    chk({tag, " busy"}, 32'(busy), 32'(v.busy));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(v.terr));
  endtask

  vec_t tbl [$];
  int   pulses;

  initial begin
    rst = 1'b1; req = '0; flit_in = '0;

    // Packet on port 0 then back-to-back grant to port 2
    tbl.push_back(mk(1, 5'b00000, '0, 5'b00000, 5'b00000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 5'b00101, pk(HS_S, NONE, HS_S, NONE, NONE), 5'b00001, 5'b00001, 1, HS_S, 1, 0));
    tbl.push_back(mk(0, 5'b00101, pk(BODY, NONE, HS_S, NONE, NONE), 5'b00001, 5'b00001, 1, BODY, 1, 0));
    tbl.push_back(mk(0, 5'b00101, pk(TAIL, NONE, HS_S, NONE, NONE), 5'b00001, 5'b00001, 1, TAIL, 0, 0));
    tbl.push_back(mk(0, 5'b00101, pk(HS_S, NONE, HS_S, NONE, NONE), 5'b00100, 5'b00100, 1, HS_S, 1, 0));
    // Non-owner requests while the owner stalls
    tbl.push_back(mk(0, 5'b00001, pk(HS_S, NONE, NONE, NONE, NONE), 5'b00000, 5'b00100, 0, HS_S, 1, 0));
    tbl.push_back(mk(0, 5'b00100, pk(NONE, NONE, TAIL, NONE, NONE), 5'b00100, 5'b00100, 1, TAIL, 0, 0));
    tbl.push_back(mk(0, 5'b00000, '0, 5'b00000, 5'b00000, 0, TAIL, 0, 0));
    // Receiving handshake on port 3 is single-flit
    tbl.push_back(mk(0, 5'b01000, pk(NONE, NONE, NONE, HS_R, NONE), 5'b01000, 5'b01000, 1, HS_R, 0, 0));
    tbl.push_back(mk(0, 5'b00000, '0, 5'b00000, 5'b00000, 0, HS_R, 0, 0));
    // Body, tail and idle flits are not eligible in IDLE
    tbl.push_back(mk(0, 5'b11111, pk(BODY, TAIL, NONE, BODY, NONE), 5'b00000, 5'b00000, 0, HS_R, 0, 0));
    // Fairness: all ports with receiving handshakes
    tbl.push_back(mk(1, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b00000, 5'b00000, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b00001, 5'b00001, 1, HS_R, 0, 0));
    tbl.push_back(mk(0, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b00010, 5'b00010, 1, HS_R, 0, 0));
    tbl.push_back(mk(0, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b00100, 5'b00100, 1, HS_R, 0, 0));
    tbl.push_back(mk(0, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b01000, 5'b01000, 1, HS_R, 0, 0));
    tbl.push_back(mk(0, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b10000, 5'b10000, 1, HS_R, 0, 0));
    tbl.push_back(mk(0, 5'b11111, pk(HS_R, HS_R, HS_R, HS_R, HS_R), 5'b00001, 5'b00001, 1, HS_R, 0, 0));

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Stall timeout: port 1 owns the shifter, then drops req for 8 cycles
    apply("to_rst", mk(1, 5'b00000, '0, 5'b00000, 5'b00000, 0, NONE, 0, 0));
    apply("to_hs", mk(0, 5'b00010, pk(NONE, HS_S, NONE, NONE, NONE), 5'b00010, 5'b00010, 1, HS_S, 1, 0));
    apply("to_body", mk(0, 5'b00010, pk(NONE, BODY, NONE, NONE, NONE), 5'b00010, 5'b00010, 1, BODY, 1, 0));
    pulses = 0;
    for (int s = 0; s < 8; s++) begin
      if (s < 7)
        apply($sformatf("to_stall%0d", s), mk(0, 5'b00000, '0, 5'b00000, 5'b00010, 0, BODY, 1, 0));
      else
        apply($sformatf("to_stall%0d", s), mk(0, 5'b00000, '0, 5'b00000, 5'b00000, 0, BODY, 0, 1));
      if (timeout_err) pulses++;
    end
    for (int s = 0; s < 3; s++) begin
      apply($sformatf("to_after%0d", s), mk(0, 5'b00000, '0, 5'b00000, 5'b00000, 0, BODY, 0, 0));
      if (timeout_err) pulses++;
    end
    chk("to_pulse_count", 32'(pulses), 32'd1);

    // Reset mid-packet, then a fresh handshake on port 0
    apply("mr_rst", mk(1, 5'b00000, '0, 5'b00000, 5'b00000, 0, NONE, 0, 0));
    apply("mr_hs", mk(0, 5'b00001, pk(HS_S, NONE, NONE, NONE, NONE), 5'b00001, 5'b00001, 1, HS_S, 1, 0));
    apply("mr_body", mk(0, 5'b00001, pk(BODY, NONE, NONE, NONE, NONE), 5'b00001, 5'b00001, 1, BODY, 1, 0));
    apply("mr_hit", mk(1, 5'b00001, pk(BODY, NONE, NONE, NONE, NONE), 5'b00000, 5'b00000, 0, NONE, 0, 0));
    apply("mr_new", mk(0, 5'b00001, pk(HS_S, NONE, NONE, NONE, NONE), 5'b00001, 5'b00001, 1, HS_S, 1, 0));
    apply("mr_tail", mk(0, 5'b00001, pk(TAIL, NONE, NONE, NONE, NONE), 5'b00001, 5'b00001, 1, TAIL, 0, 0));
    apply("mr_idle", mk(0, 5'b00000, '0, 5'b00000, 5'b00000, 0, TAIL, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
